// File: rtl/conv1_pool_pkg.sv
// conv1_pkg: shared definitions for the conv1 2x2 max-pool block.
//   FMAP_DIM / POOL_DIM : default input edge length and pooled edge length.
//   row_state_t         : which row of a 2-row pooling band is streaming.
//   max_u               : unsigned max; ties return the (equal) value.
package conv1_pkg;

  localparam int FMAP_DIM = 24;
  localparam int POOL_DIM = FMAP_DIM / 2;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_t;

  // Operands are zero-extended to 32 bits by the caller and truncated back,
  // so one helper serves every bW up to 32.
  function automatic logic [31:0] max_u(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/conv1_pool_if.sv
// conv1_pool_if: streaming handshake bundle for conv1_pool.
//   s_valid/s_ready/s_data : raster-order input stream into the pool block.
//   m_valid/m_ready/m_data/m_last : pooled output stream out of the block.
// Modports:
//   master : the environment side (drives input stream, accepts output).
//   slave  : the pool block itself.
interface conv1_pool_if #(
  parameter int bW = 8
);
  logic          s_valid;
  logic          s_ready;
  logic [bW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [bW-1:0] m_data;
  logic          m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/conv1_pool_linebuf.sv
// conv1_pool_linebuf: one-row buffer of horizontal pair maxima.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable, raddr : read address, rdata : registered read data
// Memory is an inferred RAM with registered read and no reset; contents are
// always written on an even row before being read on the following odd row.
module conv1_pool_linebuf #(
  parameter int bW    = 8,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [bW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [bW-1:0] rdata
);
  logic [bW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // rdata only moves on a read, so it holds across any input stall.
    if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/conv1_pool.sv
// conv1_pool: streaming 2x2 max-pool over an FMAP x FMAP unsigned feature map.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : conv1_pool_if.slave (s_valid/s_ready/s_data in, m_* out)
// Optional feature (macro CONV1_POOL_BIN_EN):
//   threshold : binarisation threshold
//   m_bit     : m_data >= threshold, registered with m_data
//   bin_map   : one bit per pooled output of the frame, raster order
//   bin_valid : one-cycle pulse after the frame's m_last output transfer
// Even columns latch h_reg; odd columns form the horizontal pair max. On even
// rows that max goes into the line buffer; on odd rows it is combined with the
// buffered value to produce one pooled output.
module conv1_pool
  import conv1_pkg::*;
#(
  parameter int bW   = 8,
  parameter int FMAP = FMAP_DIM
) (
  input  logic            clk,
  input  logic            rst,
  conv1_pool_if.slave     bus
`ifdef CONV1_POOL_BIN_EN
  ,
  input  logic [bW-1:0]                  threshold,
  output logic                           m_bit,
  output logic [(FMAP/2)*(FMAP/2)-1:0]   bin_map,
  output logic                           bin_valid
`endif
);
  localparam int PDIM = FMAP / 2;
  localparam int CW   = (FMAP > 2) ? $clog2(FMAP) : 1;
  localparam int AW   = (PDIM > 2) ? $clog2(PDIM) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FMAP - 1);

  row_state_t    state_reg;
  logic [CW-1:0] col_reg;
  logic [CW-1:0] row_reg;
  logic [bW-1:0] h_reg;
  logic [bW-1:0] m_data_reg;
  logic          m_valid_reg;
  logic          m_last_reg;

  logic          s_ready;
  logic          in_xfer;
  logic          out_xfer;
  logic          col_odd;
  logic          col_last;
  logic          row_last;
  logic          pool_load;
  logic          lb_we;
  logic          lb_re;
  logic [AW-1:0] lb_addr;
  logic [bW-1:0] lb_rdata;
  logic [bW-1:0] hmax;
  logic [bW-1:0] vmax;

  assign s_ready   = !m_valid_reg || bus.m_ready;
  assign in_xfer   = bus.s_valid && s_ready;
  assign out_xfer  = m_valid_reg && bus.m_ready;
  assign col_odd   = col_reg[0];
  assign col_last  = (col_reg == LAST_IDX);
  assign row_last  = (row_reg == LAST_IDX);
  assign lb_addr   = AW'(col_reg >> 1);

  assign hmax = bW'(max_u(32'(h_reg), 32'(bus.s_data)));
  assign vmax = bW'(max_u(32'(lb_rdata), 32'(hmax)));

  assign lb_we     = in_xfer && col_odd && (state_reg == ROW_EVEN);
  // Read is issued on the even column so the registered data is ready when
  // the matching odd column arrives (same col>>1 index).
  assign lb_re     = in_xfer && !col_odd && (state_reg == ROW_ODD);
  assign pool_load = in_xfer && col_odd && (state_reg == ROW_ODD);

  conv1_pool_linebuf #(
    .bW    (bW),
    .DEPTH (PDIM),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (hmax),
    .re    (lb_re),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ROW_EVEN;
      col_reg     <= '0;
      row_reg     <= '0;
      h_reg       <= '0;
      m_data_reg  <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end else begin
      if (out_xfer) begin
        m_valid_reg <= 1'b0;
      end
      if (in_xfer) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + CW'(1);
        end else begin
          col_reg <= col_reg + CW'(1);
        end
        case (state_reg)
          ROW_EVEN: if (col_last) state_reg <= ROW_ODD;
          ROW_ODD:  if (col_last) state_reg <= ROW_EVEN;
          default:  state_reg <= ROW_EVEN;
        endcase
        if (!col_odd) begin
          h_reg <= bus.s_data;
        end
      end
      // A load can only happen when s_ready is high, i.e. the held output is
      // either absent or leaving this cycle; this overrides the clear above.
      if (pool_load) begin
        m_data_reg  <= vmax;
        m_valid_reg <= 1'b1;
        m_last_reg  <= row_last && col_last;
      end
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_reg;
  assign bus.m_data  = m_data_reg;
  assign bus.m_last  = m_last_reg;

`ifdef CONV1_POOL_BIN_EN
  localparam int NOUT = PDIM * PDIM;
  localparam int KW   = (NOUT > 2) ? $clog2(NOUT) : 1;

  logic            m_bit_reg;
  logic            bin_valid_reg;
  logic [KW-1:0]   out_k_reg;
  logic [NOUT-1:0] bin_map_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bit_reg     <= 1'b0;
      bin_valid_reg <= 1'b0;
      out_k_reg     <= '0;
    end else begin
      if (pool_load) begin
        m_bit_reg <= (vmax >= threshold);
      end
      bin_valid_reg <= out_xfer && m_last_reg;
      if (out_xfer) begin
        out_k_reg <= m_last_reg ? '0 : out_k_reg + KW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_bin
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bin_map_reg[gi] <= 1'b0;
      end else if (out_xfer && (out_k_reg == KW'(gi))) begin
        bin_map_reg[gi] <= m_bit_reg;
      end
    end
  end

  assign m_bit     = m_bit_reg;
  assign bin_map   = bin_map_reg;
  assign bin_valid = bin_valid_reg;
`endif

endmodule
